// File: rtl/handshake_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : handshake_rr_arbiter
// Purpose  : Packet-granular round-robin arbiter that merges NUM_SRC
//            valid/ready sources into one registered output channel.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        i_s_valid,
    input  logic [NUM_SRC*DATA_W-1:0] i_s_data,
    input  logic [NUM_SRC-1:0]        i_s_last,
    output logic [NUM_SRC-1:0]        o_s_ready,
    output logic                      o_m_valid,
    output logic [DATA_W-1:0]         o_m_data,
    output logic                      o_m_last,
    output logic [ID_W-1:0]           o_m_src,
    input  logic                      i_m_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [ID_W:0]   c_NUM_SRC_EXT = (ID_W+1)'(NUM_SRC);
    localparam logic [ID_W-1:0] c_PRIO_RESET  = ID_W'(NUM_SRC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     w_grant_nxt;
    logic [ID_W-1:0]     r_prio_ptr;
    logic [ID_W-1:0]     w_prio_nxt;

    logic                r_m_valid;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_m_last;
    logic [ID_W-1:0]     r_m_src;

    logic [ID_W:0]       w_idx;
    logic                w_found;
    logic [ID_W-1:0]     w_pick;
    logic                w_any_valid;

    logic                w_sel_valid;
    logic                w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_can_accept;
    logic                w_s_xfer;

    // Rotating priority: scan from the source after the last packet winner.
    always_comb begin
        w_idx       = '0;
        w_found     = 1'b0;
        w_pick      = '0;
        w_any_valid = |i_s_valid;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = {1'b0, r_prio_ptr} + (ID_W+1)'(k);
            if (w_idx >= c_NUM_SRC_EXT) begin
                w_idx = w_idx - c_NUM_SRC_EXT;
            end
            if (!w_found && i_s_valid[w_idx[ID_W-1:0]]) begin
                w_pick  = w_idx[ID_W-1:0];
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_valid = i_s_valid[i];
                w_sel_last  = i_s_last[i];
                w_sel_data  = i_s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The output register can take a new beat when empty or draining this cycle.
    assign w_can_accept = !r_m_valid || i_m_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio_ptr;
        o_s_ready   = '0;
        w_s_xfer    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (r_grant == ID_W'(i)) begin
                        o_s_ready[i] = w_can_accept;
                    end
                end
                w_s_xfer = w_sel_valid && w_can_accept;
                if (w_s_xfer && w_sel_last) begin
                    w_prio_nxt  = r_grant;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_prio_ptr <= c_PRIO_RESET;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_prio_ptr <= w_prio_nxt;
        end
    end

    // Reload takes precedence over drain so a simultaneous in/out keeps m_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_src   <= '0;
        end else if (w_s_xfer) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_sel_data;
            r_m_last  <= w_sel_last;
            r_m_src   <= r_grant;
        end else if (r_m_valid && i_m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign o_m_valid = r_m_valid;
    assign o_m_data  = r_m_data;
    assign o_m_last  = r_m_last;
    assign o_m_src   = r_m_src;

endmodule
`default_nettype wire
